azimuth_tracker: RTL

Parametrised azimuth state machine clocked directly by the ACP clock. It replaces the fixed 12-bit, 4096-step ACP counter with a configurable-resolution counter. Added capabilities: bidirectional rotation, a revolution counter, north-offset correction, a registered ARP, preset load, and NUM_SECT programmable blanking sectors. It sits between the ACP clock generator and the trigger/clutter blocks, and feeds them azimuth and sector-blank qualifiers.

---
 rtl/azimuth_tracker.sv | 124 ++++++++++++
 1 files changed

// File: rtl/azimuth_tracker.sv
// rtl/azimuth_tracker.sv - configurable-resolution ACP azimuth counter with ARP, revolutions, north offset and blanking sectors
//
// Ports:
//   clk_ACP     one rising edge per ACP step
//   rst         asynchronous, active-high reset
//   en, dir     count enable; dir 0 = increment (CW), 1 = decrement (CCW)
//   load        preset az_raw to load_val (takes priority over counting)
//   north_ofs   north correction added to the raw azimuth
//   sect_*      per-sector start/stop/enable, sector i at [i*AZ_W +: AZ_W]
//   az_raw, az  raw and north-corrected azimuth
//   arp         one-ACP pulse when a count step lands on azimuth 0
//   rev_cnt     revolution count, +1 forward wrap, -1 reverse wrap
//   arp_seen    sticky flag, set with the first arp after reset
//   blank       per-sector in-window flags, blank_any their OR
module azimuth_tracker #(
    parameter int AZ_W        = 12,
    parameter int ACP_PER_REV = 4096,
    parameter int REV_W       = 8,
    parameter int NUM_SECT    = 2
) (
    input  logic                     clk_ACP,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     dir,
    input  logic                     load,
    input  logic [AZ_W-1:0]          load_val,
    input  logic [AZ_W-1:0]          north_ofs,
    input  logic [NUM_SECT*AZ_W-1:0] sect_start,
    input  logic [NUM_SECT*AZ_W-1:0] sect_stop,
    input  logic [NUM_SECT-1:0]      sect_en,
    output logic [AZ_W-1:0]          az_raw,
    output logic [AZ_W-1:0]          az,
    output logic                     arp,
    output logic [REV_W-1:0]         rev_cnt,
    output logic                     arp_seen,
    output logic [NUM_SECT-1:0]      blank,
    output logic                     blank_any
);

    // PER is one bit wider than AZ_W so ACP_PER_REV = 2^AZ_W is representable
    // and wrap is decided by explicit compare, never by width overflow.
    localparam logic [AZ_W:0]   PER  = (AZ_W+1)'(ACP_PER_REV);
    localparam logic [AZ_W-1:0] MAXV = AZ_W'(ACP_PER_REV - 1);

    function automatic logic [AZ_W-1:0] clamp(input logic [AZ_W-1:0] v);
        return ({1'b0, v} >= PER) ? MAXV : v;
    endfunction

    logic [AZ_W-1:0]     nraw;
    logic                fwd_wrap;
    logic                rev_wrap;
    logic                narp;
    logic [AZ_W:0]       sum;
    logic [AZ_W-1:0]     naz;
    logic [NUM_SECT-1:0] nblank;

    always_comb begin
        nraw     = az_raw;
        fwd_wrap = 1'b0;
        rev_wrap = 1'b0;
        narp     = 1'b0;
        if (load) begin
            nraw = clamp(load_val);
        end else if (en && !dir) begin
            if (az_raw == MAXV) begin
                nraw     = '0;
                fwd_wrap = 1'b1;
            end else begin
                nraw = az_raw + AZ_W'(1);
            end
            narp = (nraw == '0);
        end else if (en && dir) begin
            if (az_raw == '0) begin
                nraw     = MAXV;
                rev_wrap = 1'b1;
            end else begin
                nraw = az_raw - AZ_W'(1);
            end
            // Stepping down from 1 lands on north and produces the ARP.
            narp = (nraw == '0);
        end

        // Both operands are below ACP_PER_REV, so one subtraction suffices.
        sum = {1'b0, nraw} + {1'b0, clamp(north_ofs)};
        naz = (sum >= PER) ? AZ_W'(sum - PER) : sum[AZ_W-1:0];

        nblank = '0;
        for (int i = 0; i < NUM_SECT; i++) begin
            logic [AZ_W-1:0] s;
            logic [AZ_W-1:0] t;
            s = clamp(sect_start[i*AZ_W +: AZ_W]);
            t = clamp(sect_stop[i*AZ_W +: AZ_W]);
            if (s <= t)
                nblank[i] = sect_en[i] && (naz >= s) && (naz <= t);
            else
                nblank[i] = sect_en[i] && ((naz >= s) || (naz <= t));
        end
    end

    always_ff @(posedge clk_ACP or posedge rst) begin
        if (rst) begin
            az_raw    <= '0;
            az        <= '0;
            arp       <= 1'b0;
            rev_cnt   <= '0;
            arp_seen  <= 1'b0;
            blank     <= '0;
            blank_any <= 1'b0;
        end else begin
            az_raw    <= nraw;
            az        <= naz;
            arp       <= narp;
            blank     <= nblank;
            blank_any <= |nblank;
            if (narp)
                arp_seen <= 1'b1;
            if (fwd_wrap)
                rev_cnt <= rev_cnt + REV_W'(1);
            else if (rev_wrap)
                rev_cnt <= rev_cnt - REV_W'(1);
        end
    end

endmodule
